// File: rtl/data_mem_readback.sv
// ============================================================================
// Module   : data_mem_readback
// Purpose  : Walks a data-memory location range, reads each word and streams
//            it out over a valid/ready handshake with a 2-entry skid FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_readback #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_loc,
    input  logic [ADDR_W-1:0] last_loc,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_loc,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_rem_one   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_loc;
    logic              r_inflight_last;

    logic [DATA_W-1:0] r_fifo_data [2];
    logic [ADDR_W-1:0] r_fifo_loc  [2];
    logic              r_fifo_last [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_occ;

    logic              w_pop;
    logic              w_flush;
    logic              w_issue;
    logic              w_last_issue;
    logic [2:0]        w_pending;
    logic [ADDR_W-1:0] w_span;
    logic [ADDR_W-1:0] w_addr_next;

    assign w_flush   = abort && (r_state != S_IDLE);
    assign w_pop     = out_valid && out_ready;
    // Words buffered plus the one in flight, net of this cycle's pop.
    assign w_pending = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue   = (r_state == S_READ) && !abort && (w_pending < 3'd2);
    assign w_last_issue = w_issue && (r_remaining == c_rem_one);
    assign w_span    = last_loc - first_loc;
    assign w_addr_next = (r_addr == c_last_addr) ? '0 : r_addr + c_addr_one;

    assign mem_rd_en   = w_issue;
    assign mem_rd_addr = w_issue ? r_addr : '0;

    assign out_valid = (r_occ != 2'd0);
    assign out_data  = out_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign out_loc   = out_valid ? r_fifo_loc[r_rd_ptr]  : '0;
    assign out_last  = out_valid ? r_fifo_last[r_rd_ptr] : 1'b0;
    assign busy      = (r_state == S_READ) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_READ;
            end
            S_READ: begin
                if (abort)             w_state_next = S_IDLE;
                else if (w_last_issue) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort)                  w_state_next = S_IDLE;
                else if (w_pop && out_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Address walk and the single outstanding read slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_loc  <= '0;
            r_inflight_last <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_addr      <= first_loc;
                r_remaining <= {1'b0, w_span} + c_rem_one;
            end else if (w_issue) begin
                r_addr      <= w_addr_next;
                r_remaining <= r_remaining - c_rem_one;
            end
            r_inflight      <= w_issue && !w_flush;
            r_inflight_loc  <= r_addr;
            r_inflight_last <= w_last_issue;
        end
    end

    // Returned data lands in the FIFO at the end of the cycle it is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_loc[i]  <= '0;
                r_fifo_last[i] <= 1'b0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else if (w_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_fifo_data[r_wr_ptr] <= mem_rd_data;
                r_fifo_loc[r_wr_ptr]  <= r_inflight_loc;
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_readback.sv
// ============================================================================
// Module   : tb_data_mem_readback
// Purpose  : Table-driven and randomized checks of data_mem_readback against a
//            queue-based model of the expected word stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_readback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  first_loc = '0;
    logic [3:0]  last_loc = '0;
    logic        mem_rd_en;
    logic [3:0]  mem_rd_addr;
    logic [63:0] mem_rd_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [3:0]  out_loc;
    logic        out_last;
    logic        busy;
    logic        done;

    data_mem_readback #(.DATA_W(64), .ADDR_W(4), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .first_loc(first_loc), .last_loc(last_loc),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_loc(out_loc), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    always @(posedge clk) cyc++;

    // Data memory: registered read port, garbage when not reading.
    logic [63:0] mem [16];
    always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : {$urandom, $urandom};

    // Consumer: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random, 3 = never.
    int ready_mode = 0;
    int pidx = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (pidx % 4 == 0) || (pidx % 4 == 3);
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
        pidx++;
    end

    typedef struct packed {
        logic [63:0] d;
        logic [3:0]  l;
        logic        last;
    } word_t;

    word_t expq[$];
    int xfer_count, done_count, first_rd_cyc, first_xfer_cyc, last_xfer_cyc, done_cyc;
    int outstanding = 0;
    logic m_pop;
    logic prev_hold = 1'b0;
    logic [63:0] prev_d;
    logic [3:0]  prev_l;
    logic        prev_last;

    // Monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            outstanding = 0;
            prev_hold   = 1'b0;
        end else begin
            m_pop = out_valid && out_ready && !abort;
            if (!mem_rd_en) begin
                chk("rd_addr_idle_zero", 64'(mem_rd_addr), 64'd0);
            end else begin
                chk("issue_rule", 64'((outstanding - int'(out_valid && out_ready)) < 2), 64'd1);
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            if (prev_hold) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", out_data, prev_d);
                chk("hold_loc", 64'(out_loc), 64'(prev_l));
                chk("hold_last", 64'(out_last), 64'(prev_last));
            end
            if (m_pop) begin
                if (expq.size() == 0) begin
                    chk("unexpected_word", 64'd1, 64'd0);
                end else begin
                    word_t w;
                    w = expq.pop_front();
                    chk("word_data", out_data, w.d);
                    chk("word_loc", 64'(out_loc), 64'(w.l));
                    chk("word_last", 64'(out_last), 64'(w.last));
                end
                xfer_count++;
                if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            outstanding = outstanding + int'(mem_rd_en) - int'(out_valid && out_ready);
            if (abort && (busy || done || out_valid)) outstanding = 0;
            prev_hold = out_valid && !out_ready && !abort;
            prev_d    = out_data;
            prev_l    = out_loc;
            prev_last = out_last;
        end
    end

    task automatic clear_stats();
        xfer_count = 0; done_count = 0;
        first_rd_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1; done_cyc = -1;
        expq.delete();
    endtask

    function automatic int dump_len(input int f, input int l);
        return ((l - f) % 16 + 16) % 16 + 1;
    endfunction

    task automatic build_expected(input int f, input int l);
        int n;
        n = dump_len(f, l);
        for (int k = 0; k < n; k++) begin
            word_t w;
            w.l    = 4'((f + k) % 16);
            w.d    = mem[(f + k) % 16];
            w.last = (k == n - 1);
            expq.push_back(w);
        end
    endtask

    task automatic pulse_start(input int f, input int l, output int t0);
        @(posedge clk); #1;
        start = 1'b1; first_loc = 4'(f); last_loc = 4'(l);
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b0; first_loc = 4'($urandom); last_loc = 4'($urandom);
    endtask

    task automatic run_dump(input int f, input int l, input int mode,
                            input int ab, input int poke, input int expn);
        int t0, n, abort_cyc;
        bit aborted;
        n = dump_len(f, l);
        aborted = 0;
        abort_cyc = 0;
        clear_stats();
        ready_mode = mode;
        @(posedge clk);
        build_expected(f, l);
        pulse_start(f, l, t0);
        for (int i = 0; i < 400; i++) begin
            if (poke != 0 && (cyc == t0 + 3 || cyc == t0 + n + 2)) begin
                start = 1'b1; first_loc = 4'd5; last_loc = 4'd5;
            end else begin
                start = 1'b0;
            end
            if (aborted && cyc == abort_cyc + 1) begin
                abort = 1'b0;
                @(negedge clk);
                chk("abort_valid_low", 64'(out_valid), 64'd0);
                chk("abort_busy_low", 64'(busy), 64'd0);
                repeat (4) @(negedge clk);
                break;
            end
            if (ab >= 0 && !aborted && xfer_count == ab) begin
                abort = 1'b1; aborted = 1; abort_cyc = cyc;
            end
            if (done_count > 0) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        abort = 1'b0;
        chk("xfer_count", 64'(xfer_count), 64'(expn));
        if (ab >= 0) begin
            chk("abort_no_done", 64'(done_count), 64'd0);
            expq.delete();
        end else begin
            chk("all_words_seen", 64'(expq.size()), 64'd0);
            chk("done_once", 64'(done_count), 64'd1);
            chk("done_after_last", 64'(done_cyc), 64'(last_xfer_cyc + 1));
            if (mode == 0) begin
                chk("first_rd_cycle", 64'(first_rd_cyc), 64'(t0));
                chk("first_xfer_cycle", 64'(first_xfer_cyc), 64'(t0 + 2));
                chk("last_xfer_cycle", 64'(last_xfer_cyc), 64'(t0 + n + 1));
                chk("done_cycle", 64'(done_cyc), 64'(t0 + n + 2));
            end
        end
        repeat (3) begin
            @(negedge clk);
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_valid", 64'(out_valid), 64'd0);
            chk("idle_done", 64'(done), 64'd0);
        end
    endtask

    typedef struct {
        int f;
        int l;
        int mode;
        int ab;
        int poke;
        int expn;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int t0;
        for (int i = 0; i < 16; i++) mem[i] = 64'd0;
        mem[0] = 64'd45;
        mem[1] = 64'd20;
        mem[2] = 64'hFFFF_FFFF_FFFF_FFEC;

        vecs[0] = '{0, 15, 0, -1, 0, 16};
        vecs[1] = '{0, 15, 1, -1, 0, 16};
        vecs[2] = '{14, 1, 0, -1, 0, 4};
        vecs[3] = '{2, 2, 0, -1, 0, 1};
        vecs[4] = '{0, 15, 0, 5, 0, 5};
        vecs[5] = '{3, 3, 0, -1, 0, 1};
        vecs[6] = '{0, 15, 0, -1, 1, 16};
        vecs[7] = '{14, 1, 1, -1, 0, 4};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_en", 64'(mem_rd_en), 64'd0);
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        clear_stats();

        // Abort in IDLE must do nothing.
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("idle_abort_busy", 64'(busy), 64'd0);

        foreach (vecs[i])
            run_dump(vecs[i].f, vecs[i].l, vecs[i].mode, vecs[i].ab, vecs[i].poke, vecs[i].expn);

        // Reset asserted mid-dump with both FIFO entries occupied.
        clear_stats();
        ready_mode = 3;
        @(posedge clk);
        build_expected(0, 15);
        pulse_start(0, 15, t0);
        repeat (6) @(posedge clk);
        #1;
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_rd_en", 64'(mem_rd_en), 64'd0);
        chk("arst_rd_addr", 64'(mem_rd_addr), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_data", out_data, 64'd0);
        chk("arst_loc", 64'(out_loc), 64'd0);
        chk("arst_last", 64'(out_last), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        expq.delete();
        ready_mode = 0;
        repeat (20) begin
            @(negedge clk);
            chk("post_reset_valid", 64'(out_valid), 64'd0);
            chk("post_reset_busy", 64'(busy), 64'd0);
        end
        chk("post_reset_xfers", 64'(xfer_count), 64'd0);

        // Randomized memory contents, ranges and backpressure.
        for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
        for (int r = 0; r < 10; r++) begin
            int f, l;
            f = int'($urandom_range(0, 15));
            l = int'($urandom_range(0, 15));
            run_dump(f, l, 2, -1, 0, dump_len(f, l));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_mem_readback.md
Name: data_mem_readback

Overview:
- Readback engine for the pipelined datapath's data memory. The existing loader writes the memory through the data-memory load cycle (data, data_location); this block reads it back.
- On command, it walks a location range, issues single-cycle reads into the data memory's read port, and streams each 64-bit word out through a valid/ready handshake.
- Benches and debug logic use it to dump results after a program completes.

Parameters:
- DATA_W, 64, width of one data-memory word
- ADDR_W, 4, location index width
- DEPTH, 16, number of data-memory locations (2**ADDR_W)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a dump; sampled only in IDLE
- abort  in  1  synchronous cancel of a dump in progress
- first_loc  in  ADDR_W  first location, captured on start
- last_loc  in  ADDR_W  last location (inclusive), captured on start
- mem_rd_en  out  1  read strobe to the data memory
- mem_rd_addr  out  ADDR_W  read location
- mem_rd_data  in  DATA_W  read data, valid exactly one cycle after mem_rd_en
- out_valid  out  1  out_data, out_loc and out_last are valid
- out_ready  in  1  consumer accepts the word
- out_data  out  DATA_W  word read
- out_loc  out  ADDR_W  location of out_data
- out_last  out  1  marks the final word of the dump
- busy  out  1  high in READ and DRAIN
- done  out  1  one-cycle pulse after the final word is accepted

Behaviour:
- Reset: asynchronous, active-low. All outputs go to 0, the FIFO empties, in-flight reads are discarded, and the state becomes IDLE. Reset may assert mid-dump; after release, nothing from the interrupted dump appears at the output.
- States:
  - IDLE: start=1 captures first_loc and last_loc, sets count = ((last_loc - first_loc) mod DEPTH) + 1, and moves to READ.
  - READ: issues reads. After the read for the last location is issued, moves to DRAIN.
  - DRAIN: waits for the final word to be accepted, then moves to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Address walk: starts at first_loc and increments modulo DEPTH. It wraps from DEPTH-1 to 0. first_loc > last_loc is a legal wrapped range; first_loc == last_loc is a one-word dump.
- Read issue:
  - mem_rd_en=1 in READ when (fifo_occupancy + inflight - pop) < 2, where pop = out_valid & out_ready.
  - One read is issued per asserting cycle.
  - mem_rd_addr is held stable while mem_rd_en=1 and is 0 whenever mem_rd_en=0.
- Buffering:
  - A 2-entry FIFO holds {data, loc, last}. The word returned on mem_rd_data is written at the end of the cycle it is valid.
  - The FIFO can never overflow; the issue rule guarantees this.
- Handshake:
  - out_valid = FIFO non-empty. The head entry drives out_data, out_loc and out_last.
  - Once out_valid=1, the head entry must not change until it is accepted.
  - A transfer occurs on a cycle with out_valid & out_ready.
- Latency: start is sampled at edge T. The first mem_rd_en is in cycle T+1, data is returned in T+2, and out_valid rises in T+3.
- Throughput: with out_ready held at 1, one word per cycle. A count-N dump has its final transfer in cycle T+N+2 and done in T+N+3.
- Backpressure: with out_ready=0, at most 2 words are buffered and reads stall. No word is lost or duplicated.
- out_last: set only on the entry for the final location.
- start:
  - Ignored outside IDLE.
  - start in the same cycle as a DONE pulse is ignored.
- abort:
  - Takes effect in any non-IDLE state.
  - Next cycle: IDLE with the FIFO flushed, the in-flight read dropped, out_valid=0, and no done pulse.
  - abort takes priority over a simultaneous transfer; that word counts as not delivered.
  - abort in IDLE has no effect.
- busy=1 in READ and DRAIN; it is 0 in IDLE and DONE.

Test Plan:
- Memory preloaded with loc0=45, loc1=20, loc2=-20 (0xFFFFFFFFFFFFFFEC), others 0. Dump 0..15 with out_ready=1 -> 16 transfers in consecutive cycles T+3..T+18, values 45, 20, 0xFFFF_FFFF_FFFF_FFEC, then 0, with out_loc 0..15. out_last only with loc15; done at T+19.
- Same dump with out_ready toggling 1,0,0,1 repeatedly -> same 16 words in order, no duplicates. mem_rd_en never asserts when 2 words are held plus 0 pops. Held outputs stay stable while out_ready=0.
- Wrap range first_loc=14, last_loc=1 -> exactly 4 words with locs 14,15,0,1; out_last on loc1.
- Single location first_loc=last_loc=2 -> one transfer of -20 with out_last=1; done 1 cycle after acceptance.
- abort after the 5th transfer of a 0..15 dump -> out_valid=0 and busy=0 next cycle, no done pulse. A following start 3..3 dumps only loc3. start pulsed while busy is ignored (no restart).
- rst_n low for 1 cycle mid-dump, while 2 words are buffered -> all outputs 0 immediately (asynchronously). After release, IDLE with no residual words.
